// File: rtl/aes128_round_sequencer_pkg.sv
// Shared constants, FSM encoding and GF(2^8) helpers for the iterative AES-128 engine.
package aes128_round_sequencer_pkg;

  localparam int AES_NR = 10;

  localparam logic [1:10][7:0] AES_RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } fsm_t;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Multiply by x in GF(2^8), reduction polynomial 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes128_round_sequencer_mixcolumn.sv
// MixColumns over the full 128-bit column-major state (four independent columns).
module mixcolumn
  import aes128_round_sequencer_pkg::*;
(
  input  logic [127:0] data,
  output logic [127:0] mixed
);

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign {a0, a1, a2, a3} = data[127-32*c -: 32];
    // Each output byte is 2*a[i] ^ 3*a[i+1] ^ a[i+2] ^ a[i+3].
    assign mixed[127-32*c -: 32] = {
      xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
      a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
      a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
      xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
    };
  end

endmodule

// File: rtl/aes128_round_sequencer_sbox.sv
// 8-bit combinational AES forward S-box.
module aes_sbox
  import aes128_round_sequencer_pkg::*;
(
  input  logic [7:0] x,
  output logic [7:0] y
);

  assign y = SBOX[x];

endmodule

// File: rtl/aes128_round_sequencer.sv
// Iterative AES-128 encryption: one round per clock through a shared round datapath,
// with on-the-fly key expansion and valid/ready handshakes on both streams.
module aes128_round_sequencer
  import aes128_round_sequencer_pkg::*;
#(
  parameter int NR       = AES_NR,
  parameter bit HOLD_KEY = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] pt_in,
  input  logic [127:0] key_in,
  input  logic         key_load,
  output logic [127:0] ct_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic [3:0]   round_idx
);

  if (NR != AES_NR) begin : g_bad_nr
    $error("aes128_round_sequencer: NR must be 10 for AES-128");
  end

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  fsm_t         fsm, fsm_next;
  logic [127:0] st, rk, key_reg;
  logic [3:0]   round;
  logic         accept, last_round;
  logic [127:0] blk_key, sb, sr, mc, rk_next, round_out;
  logic [31:0]  rot_word, sub_word;

  assign accept     = in_valid & in_ready;
  assign last_round = (round == LAST_ROUND);
  assign blk_key    = HOLD_KEY ? key_reg : key_in;

  // SubBytes and ShiftRows: byte r+4c moves to column c from column (c+r) mod 4.
  for (genvar i = 0; i < 16; i++) begin : g_sub_bytes
    aes_sbox u_sbox (.x(st[127-8*i -: 8]), .y(sb[127-8*i -: 8]));
  end

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign sr[127-8*(r+4*c) -: 8] = sb[127-8*(r+4*((c+r)%4)) -: 8];
    end
  end

  mixcolumn u_mix (.data(sr), .mixed(mc));

  // Key schedule: SubWord(RotWord(w3)) feeds the first word of the next round key.
  assign rot_word = {rk[23:0], rk[31:24]};
  for (genvar j = 0; j < 4; j++) begin : g_sub_word
    aes_sbox u_sbox (.x(rot_word[31-8*j -: 8]), .y(sub_word[31-8*j -: 8]));
  end

  always_comb begin
    rk_next[127:96] = rk[127:96] ^ sub_word ^ {AES_RCON[round], 24'h0};
    rk_next[95:64]  = rk_next[127:96] ^ rk[95:64];
    rk_next[63:32]  = rk_next[95:64]  ^ rk[63:32];
    rk_next[31:0]   = rk_next[63:32]  ^ rk[31:0];
    round_out       = (last_round ? sr : mc) ^ rk_next;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm <= S_IDLE;
    else        fsm <= fsm_next;
  end

  always_comb begin
    fsm_next = fsm;
    unique case (fsm)
      S_IDLE:  if (in_valid)  fsm_next = S_ROUND;
      S_ROUND: if (last_round) fsm_next = S_DONE;
      S_DONE:  if (out_ready) fsm_next = in_valid ? S_ROUND : S_IDLE;
      default: fsm_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (fsm == S_IDLE) | ((fsm == S_DONE) & out_ready);
    out_valid = (fsm == S_DONE);
    busy      = (fsm == S_ROUND);
    round_idx = busy ? round : 4'd0;
  end

  // NOTE: the datapath is cleared on reset so an aborted block leaves no partial ciphertext or key behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= '0;
      rk     <= '0;
      ct_out <= '0;
      round  <= '0;
    end else if (accept) begin
      st    <= pt_in ^ blk_key;
      rk    <= blk_key;
      round <= 4'd1;
    end else if (fsm == S_ROUND) begin
      st    <= round_out;
      rk    <= rk_next;
      round <= last_round ? 4'd0 : round + 4'd1;
      if (last_round) ct_out <= round_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         key_reg <= '0;
    else if (HOLD_KEY && key_load && (fsm == S_IDLE))   key_reg <= key_in;
  end

endmodule

// File: tb/tb_aes128_round_sequencer.sv
// Directed FIPS-197 vectors, backpressure, back-to-back, mid-block reset and held-key checks.
module tb_aes128_round_sequencer;

  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 0, key_load = 0, out_ready = 0;
  logic [127:0] pt_in = '0, key_in = '0;
  logic         in_ready, out_valid, busy;
  logic [127:0] ct_out;
  logic [3:0]   round_idx;

  logic         in_valid_h = 0, key_load_h = 0, out_ready_h = 0;
  logic [127:0] pt_h = '0, key_h = '0;
  logic         in_ready_h, out_valid_h, busy_h;
  logic [127:0] ct_h;
  logic [3:0]   round_idx_h;

  int n_tests = 0;
  int n_fail  = 0;

  aes128_round_sequencer #(.NR(10), .HOLD_KEY(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .pt_in(pt_in), .key_in(key_in), .key_load(key_load), .ct_out(ct_out),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .round_idx(round_idx)
  );

  aes128_round_sequencer #(.NR(10), .HOLD_KEY(1'b1)) u_dut_hk (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_h), .in_ready(in_ready_h),
    .pt_in(pt_h), .key_in(key_h), .key_load(key_load_h), .ct_out(ct_h),
    .out_valid(out_valid_h), .out_ready(out_ready_h), .busy(busy_h), .round_idx(round_idx_h)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the engine idle; returns at the negedge where out_valid is seen.
  task automatic run_block(input bit hk, input logic [127:0] pt, input logic [127:0] key,
                           input logic [127:0] exp, input bit load_mid, input string tag);
    int n;
    check({tag, " in_ready"}, hk ? in_ready_h : in_ready, 1);
    if (hk) begin in_valid_h = 1; pt_h = pt; end
    else    begin in_valid = 1; pt_in = pt; key_in = key; end
    @(posedge clk);
    @(negedge clk);
    check({tag, " busy"}, hk ? busy_h : busy, 1);
    check({tag, " round1"}, hk ? round_idx_h : round_idx, 1);
    if (hk) begin in_valid_h = 0; pt_h = ~pt; end
    else    begin in_valid = 0; pt_in = ~pt; key_in = ~key; end
    n = 1;
    while (!(hk ? out_valid_h : out_valid) && n < 40) begin
      @(negedge clk);
      n++;
      if (hk) key_load_h = load_mid && (n == 3);
    end
    key_load_h = 0;
    check({tag, " latency"}, n, 11);
    check({tag, " ct"}, hk ? ct_h : ct_out, exp);
  endtask

  task automatic consume(input bit hk, input string tag);
    if (hk) out_ready_h = 1; else out_ready = 1;
    @(negedge clk);
    check({tag, " drop"}, hk ? out_valid_h : out_valid, 0);
    check({tag, " idle"}, hk ? in_ready_h : in_ready, 1);
    if (hk) out_ready_h = 0; else out_ready = 0;
  endtask

  initial begin
    int n;
    logic [127:0] held;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst out_valid", out_valid, 0);
    check("rst busy", busy, 0);
    check("rst round_idx", round_idx, 0);
    check("rst ct", ct_out, 0);
    rst_n = 1;
    @(negedge clk);
    check("rst in_ready", in_ready, 1);

    // App.B vector with latency measurement
    run_block(0, PT_B, KEY_B, CT_B, 0, "appB");

    // Backpressure: sink stalls, a waiting block must not be taken
    held = ct_out;
    in_valid = 1; pt_in = PT_C; key_in = KEY_C;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp ct stable", ct_out, held);
      check("bp in_ready", in_ready, 0);
    end
    check("bp out_valid", out_valid, 1);
    check("bp not busy", busy, 0);

    // Back-to-back: consume and accept on the same edge
    out_ready = 1;
    #1;
    check("b2b in_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    check("b2b out_valid drop", out_valid, 0);
    check("b2b busy", busy, 1);
    check("b2b round1", round_idx, 1);
    n = 1;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    check("b2b latency", n, 11);
    check("b2b ct", ct_out, CT_C);
    in_valid = 0;
    @(negedge clk);
    check("b2b drop", out_valid, 0);
    check("b2b idle busy", busy, 0);
    check("b2b idle in_ready", in_ready, 1);
    out_ready = 0;

    // App.C on its own
    run_block(0, PT_C, KEY_C, CT_C, 0, "appC");
    consume(0, "appC");

    // Reset pulse at round 5
    in_valid = 1; pt_in = PT_B; key_in = KEY_B;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    n = 0;
    while (round_idx != 4'd5 && n < 40) begin @(negedge clk); n++; end
    check("abort reach r5", round_idx, 5);
    rst_n = 0;
    #1;
    check("abort out_valid", out_valid, 0);
    check("abort round_idx", round_idx, 0);
    check("abort busy", busy, 0);
    check("abort ct", ct_out, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("abort in_ready", in_ready, 1);
    run_block(0, PT_B, KEY_B, CT_B, 0, "post-abort");
    consume(0, "post-abort");

    // Held key: load once, then three blocks with a stray key on key_in
    key_load_h = 1; key_h = KEY_B;
    @(negedge clk);
    key_load_h = 0; key_h = KEY_C;
    run_block(1, PT_B, KEY_C, CT_B, 0, "hk1");
    consume(1, "hk1");
    run_block(1, PT_B, KEY_C, CT_B, 1, "hk2");
    consume(1, "hk2");
    run_block(1, PT_B, KEY_C, CT_B, 0, "hk3");
    consume(1, "hk3");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
